xif_mem_responder: RTL and testbench

Core-side responder for the CV-X-IF memory interface of the FPU subsystem. Accepts `x_mem_req_t` transactions issued by the coprocessor (FP loads/stores), returns the synchronous `x_mem_resp_t`, waits for commit of speculative requests, and performs one OBI data-bus access per request. The matching `x_mem_result_t` goes back to the coprocessor. Sits in the core/LSU shim, opposite the FPU subsystem's memory-request initiator.

---
 rtl/xif_mem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_xif_mem_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mem_responder.sv
// -----------------------------------------------------------------------------
// xif_mem_responder
//
// Core-side responder for the CV-X-IF memory interface of the FPU subsystem.
// It accepts one FP load/store request at a time from the coprocessor and
// answers with the synchronous memory response. Speculative requests are held
// until a matching commit arrives. Each accepted request then makes one OBI
// data-bus access, and the coprocessor gets a one-cycle result pulse.
//
// Optional feature (define the macro to enable it):
//   XIF_MEM_ALIGN_CHECK_EN - reject misaligned halfword/word accesses with a
//                            misaligned exception (exccode 4 load / 6 store)
//                            instead of sending them to the bus.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   x_mem_valid_i / x_mem_ready_o  request handshake (ready only in IDLE)
//   x_mem_req_i                    id, addr, mode, size, we, wdata, last, spec
//   x_mem_resp_o                   exc, exccode, dbg (combinational from req)
//   x_commit_valid_i, x_commit_i   commit / kill of a speculative request
//   x_mem_result_valid_o           one-cycle result pulse
//   x_mem_result_o                 id, rdata, err, dbg
//   data_req_o / data_gnt_i        OBI address phase
//   data_addr_o, data_we_o,
//   data_be_o, data_wdata_o        OBI address-phase payload (word aligned)
//   data_rvalid_i, data_rdata_i,
//   data_err_i                     OBI response phase
//
// Size encoding of x_mem_req_i.size: 0 byte, 1 halfword, 2 word, 3 doubleword.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package xif_mem_responder_pkg;

  localparam int unsigned XIF_ID_WIDTH  = 4;
  localparam int unsigned XIF_MEM_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_LOAD_FAULT       = 6'd5;
  localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;
  localparam logic [5:0] EXC_STORE_FAULT      = 6'd7;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]  id;
    logic [31:0]              addr;
    logic [1:0]               mode;
    logic                     we;
    logic [1:0]               size;
    logic [XIF_MEM_WIDTH-1:0] wdata;
    logic                     last;
    logic                     spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0] id;
    logic                    commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0]  id;
    logic [XIF_MEM_WIDTH-1:0] rdata;
    logic                     err;
    logic                     dbg;
  } x_mem_result_t;

endpackage

// State table
//   state        | meaning
//   IDLE         | ready for a request; x_mem_ready_o = 1
//   WAIT_COMMIT  | speculative request latched, waiting for commit/kill of its id
//   BUS_REQ      | OBI address phase; data_req_o = 1 until grant
//   BUS_RESP     | granted, waiting for data_rvalid_i
//   RESULT       | one-cycle result pulse to the coprocessor
module xif_mem_responder
  import xif_mem_responder_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = XIF_ID_WIDTH,
  parameter int unsigned X_MEM_WIDTH = XIF_MEM_WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,

  input  logic          x_mem_valid_i,
  output logic          x_mem_ready_o,
  input  x_mem_req_t    x_mem_req_i,
  output x_mem_resp_t   x_mem_resp_o,

  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,

  output logic          x_mem_result_valid_o,
  output x_mem_result_t x_mem_result_o,

  output logic          data_req_o,
  input  logic          data_gnt_i,
  output logic [31:0]   data_addr_o,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic          data_rvalid_i,
  input  logic [31:0]   data_rdata_i,
  input  logic          data_err_i
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_COMMIT,
    BUS_REQ,
    BUS_RESP,
    RESULT
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic [X_ID_WIDTH-1:0]  id_q;
  logic [31:0]            addr_q;
  logic [1:0]             size_q;
  logic                   we_q;
  logic [X_MEM_WIDTH-1:0] wdata_q;

  // Captured response
  logic [X_MEM_WIDTH-1:0] rdata_q;
  logic                   err_q;

  logic       latch_en;
  logic       capture_en;
  logic       resp_exc;
  logic [5:0] resp_code;
  logic       commit_now_hit;
  logic       commit_wait_hit;
  logic [3:0] be_full;

  // mode and last carry no information for this responder
  logic unused_req;
  assign unused_req = ^{x_mem_req_i.mode, x_mem_req_i.last};

  // ---------------------------------------------------------------------------
  // Synchronous response, decoded straight from the incoming request
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_exc  = 1'b0;
    resp_code = 6'd0;
    if (x_mem_req_i.size == SIZE_DOUBLE) begin
      resp_exc  = 1'b1;
      resp_code = x_mem_req_i.we ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
    end
`ifdef XIF_MEM_ALIGN_CHECK_EN
    else if (((x_mem_req_i.size == SIZE_HALF) && x_mem_req_i.addr[0]) ||
             ((x_mem_req_i.size == SIZE_WORD) && (x_mem_req_i.addr[1:0] != 2'b00))) begin
      resp_exc  = 1'b1;
      resp_code = x_mem_req_i.we ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
    end
`endif
  end

  always_comb begin
    x_mem_resp_o         = '0;
    x_mem_resp_o.exc     = resp_exc;
    x_mem_resp_o.exccode = resp_code;
    x_mem_resp_o.dbg     = 1'b0;
  end

  // A commit arriving together with a speculative handshake is compared
  // against the incoming id; later commits against the latched one.
  assign commit_now_hit  = x_commit_valid_i && (x_commit_i.id == x_mem_req_i.id);
  assign commit_wait_hit = x_commit_valid_i && (x_commit_i.id == id_q);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    x_mem_ready_o        = 1'b0;
    data_req_o           = 1'b0;
    x_mem_result_valid_o = 1'b0;
    latch_en             = 1'b0;
    capture_en           = 1'b0;

    case (state_q)
      IDLE: begin
        x_mem_ready_o = 1'b1;
        // Excepting requests are answered by the response alone.
        if (x_mem_valid_i && !resp_exc) begin
          latch_en = 1'b1;
          if (!x_mem_req_i.spec) begin
            state_d = BUS_REQ;
          end else if (commit_now_hit) begin
            state_d = x_commit_i.commit_kill ? IDLE : BUS_REQ;
          end else begin
            state_d = WAIT_COMMIT;
          end
        end
      end

      WAIT_COMMIT: begin
        if (commit_wait_hit) begin
          state_d = x_commit_i.commit_kill ? IDLE : BUS_REQ;
        end
      end

      BUS_REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) begin
          state_d = BUS_RESP;
        end
      end

      BUS_RESP: begin
        if (data_rvalid_i) begin
          capture_en = 1'b1;
          state_d    = RESULT;
        end
      end

      RESULT: begin
        x_mem_result_valid_o = 1'b1;
        state_d              = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (latch_en) begin
      id_q    <= x_mem_req_i.id;
      addr_q  <= x_mem_req_i.addr;
      size_q  <= x_mem_req_i.size;
      we_q    <= x_mem_req_i.we;
      wdata_q <= x_mem_req_i.wdata;
    end
  end

  // Read data is lane-aligned to bit 0 without extension; errors and stores
  // return zero data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (capture_en) begin
      err_q <= data_err_i;
      if (data_err_i || we_q) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= data_rdata_i >> {addr_q[1:0], 3'b000};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus address phase; payload is only driven while the request is up so the
  // idle bus reads as all zeros. Shifted lanes beyond bit 31 fall off.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (size_q)
      SIZE_BYTE: be_full = 4'b0001 << addr_q[1:0];
      SIZE_HALF: be_full = 4'b0011 << addr_q[1:0];
      default:   be_full = 4'b1111;
    endcase
  end

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      data_addr_o  = {addr_q[31:2], 2'b00};
      data_we_o    = we_q;
      data_be_o    = be_full;
      data_wdata_o = wdata_q << {addr_q[1:0], 3'b000};
    end
  end

  // ---------------------------------------------------------------------------
  // Result
  // ---------------------------------------------------------------------------
  always_comb begin
    x_mem_result_o = '0;
    if (x_mem_result_valid_o) begin
      x_mem_result_o.id    = id_q;
      x_mem_result_o.rdata = rdata_q;
      x_mem_result_o.err   = err_q;
      x_mem_result_o.dbg   = 1'b0;
    end
  end

endmodule

// File: tb/tb_xif_mem_responder.sv
`timescale 1ns/1ps
module tb_xif_mem_responder;
  import xif_mem_responder_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          x_mem_valid_i;
  logic          x_mem_ready_o;
  x_mem_req_t    x_mem_req_i;
  x_mem_resp_t   x_mem_resp_o;
  logic          x_commit_valid_i;
  x_commit_t     x_commit_i;
  logic          x_mem_result_valid_o;
  x_mem_result_t x_mem_result_o;
  logic          data_req_o;
  logic          data_gnt_i;
  logic [31:0]   data_addr_o;
  logic          data_we_o;
  logic [3:0]    data_be_o;
  logic [31:0]   data_wdata_o;
  logic          data_rvalid_i;
  logic [31:0]   data_rdata_i;
  logic          data_err_i;

  always #5 clk_i = ~clk_i;

  xif_mem_responder dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .x_mem_valid_i        (x_mem_valid_i),
    .x_mem_ready_o        (x_mem_ready_o),
    .x_mem_req_i          (x_mem_req_i),
    .x_mem_resp_o         (x_mem_resp_o),
    .x_commit_valid_i     (x_commit_valid_i),
    .x_commit_i           (x_commit_i),
    .x_mem_result_valid_o (x_mem_result_valid_o),
    .x_mem_result_o       (x_mem_result_o),
    .data_req_o           (data_req_o),
    .data_gnt_i           (data_gnt_i),
    .data_addr_o          (data_addr_o),
    .data_we_o            (data_we_o),
    .data_be_o            (data_be_o),
    .data_wdata_o         (data_wdata_o),
    .data_rvalid_i        (data_rvalid_i),
    .data_rdata_i         (data_rdata_i),
    .data_err_i           (data_err_i)
  );

  typedef struct {
    string       name;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    logic        bus_err;
    int          gnt_wait;
    int          rv_wait;
    logic        e_exc;
    logic [5:0]  e_code;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] id, input logic [31:0] addr,
                              input logic [1:0] size, input logic we, input logic [31:0] wdata,
                              input logic [31:0] bus_rdata, input logic bus_err,
                              input int gw, input int rw, input logic e_exc, input logic [5:0] e_code,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                              input logic e_err);
    vec_t v;
    v.name = name; v.id = id; v.addr = addr; v.size = size; v.we = we; v.wdata = wdata;
    v.bus_rdata = bus_rdata; v.bus_err = bus_err; v.gnt_wait = gw; v.rv_wait = rw;
    v.e_exc = e_exc; v.e_code = e_code; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic idle_inputs();
    x_mem_valid_i    = 1'b0;
    x_mem_req_i      = '0;
    x_commit_valid_i = 1'b0;
    x_commit_i       = '0;
    data_gnt_i       = 1'b0;
    data_rvalid_i    = 1'b0;
    data_rdata_i     = '0;
    data_err_i       = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_req(input vec_t v, input logic spec);
    x_mem_req_i       = '0;
    x_mem_req_i.id    = v.id;
    x_mem_req_i.addr  = v.addr;
    x_mem_req_i.size  = v.size;
    x_mem_req_i.we    = v.we;
    x_mem_req_i.wdata = v.wdata;
    x_mem_req_i.spec  = spec;
    x_mem_valid_i     = 1'b1;
  endtask

  // Entered at the negedge of the cycle data_req_o is expected to be high.
  // Plays the OBI slave with the vector's wait states and checks the result.
  task automatic bus_txn(input vec_t v);
    int  cyc = 0;
    int  phase = 0;
    int  gw = v.gnt_wait;
    int  rw = v.rv_wait;
    bit  got = 0;
    bit  stable = 1;
    bit  ready_low = 1;
    check({v.name, ".req"},   32'(data_req_o),   32'd1);
    check({v.name, ".addr"},  data_addr_o,       v.e_addr);
    check({v.name, ".be"},    32'(data_be_o),    32'(v.e_be));
    check({v.name, ".we"},    32'(data_we_o),    32'(v.we));
    check({v.name, ".wdata"}, data_wdata_o,      v.e_wdata);
    while (!got && cyc < 60) begin
      if (x_mem_result_valid_o) begin
        got = 1;
      end else begin
        if (data_req_o && (data_addr_o !== v.e_addr || data_be_o !== v.e_be ||
                           data_wdata_o !== v.e_wdata || data_we_o !== v.we)) stable = 0;
        if (x_mem_ready_o !== 1'b0) ready_low = 0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        data_err_i    = 1'b0;
        if (phase == 0) begin
          if (data_req_o) begin
            if (gw == 0) begin data_gnt_i = 1'b1; phase = 1; end
            else gw--;
          end
        end else if (phase == 1) begin
          if (rw == 0) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = v.bus_rdata;
            data_err_i    = v.bus_err;
            phase = 2;
          end else rw--;
        end
        next_cycle();
        cyc++;
      end
    end
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_err_i    = 1'b0;
    check({v.name, ".result_seen"}, 32'(got), 32'd1);
    check({v.name, ".latency"},     32'(cyc), 32'(2 + v.gnt_wait + v.rv_wait));
    check({v.name, ".bus_stable"},  32'(stable), 32'd1);
    check({v.name, ".ready_low"},   32'(ready_low), 32'd1);
    check({v.name, ".res_id"},      32'(x_mem_result_o.id),  32'(v.id));
    check({v.name, ".res_rdata"},   x_mem_result_o.rdata,    v.e_rdata);
    check({v.name, ".res_err"},     32'(x_mem_result_o.err), 32'(v.e_err));
    check({v.name, ".res_dbg"},     32'(x_mem_result_o.dbg), 32'd0);
    next_cycle();
    check({v.name, ".pulse_end"},   32'(x_mem_result_valid_o), 32'd0);
    check({v.name, ".ready_back"},  32'(x_mem_ready_o), 32'd1);
  endtask

  // Non-speculative request applied from the vector table.
  task automatic run_vec(input vec_t v);
    bit quiet = 1;
    drive_req(v, 1'b0);
    #1;
    check({v.name, ".ready"},   32'(x_mem_ready_o),        32'd1);
    check({v.name, ".exc"},     32'(x_mem_resp_o.exc),     32'(v.e_exc));
    check({v.name, ".exccode"}, 32'(x_mem_resp_o.exccode), 32'(v.e_code));
    check({v.name, ".dbg"},     32'(x_mem_resp_o.dbg),     32'd0);
    next_cycle();
    x_mem_valid_i = 1'b0;
    x_mem_req_i   = '0;
    if (v.e_exc) begin
      check({v.name, ".exc_ready"}, 32'(x_mem_ready_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (data_req_o !== 1'b0 || x_mem_result_valid_o !== 1'b0) quiet = 0;
        next_cycle();
      end
      check({v.name, ".exc_no_bus"}, 32'(quiet), 32'd1);
    end else begin
      bus_txn(v);
    end
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   quiet;

    //              name      id    addr          size       we    wdata          bus_rdata      err  gw rw exc code  e_addr        e_be     e_wdata        e_rdata        e_err
    vecs[0] = mk("wld100",  4'd1, 32'h0000_0100, SIZE_WORD, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 6'd0, 32'h0000_0100, 4'hF,   32'h0,         32'hDEAD_BEEF, 1'b0);
    vecs[1] = mk("bst203",  4'd2, 32'h0000_0203, SIZE_BYTE, 1'b1, 32'h0000_00AB, 32'h1234_5678, 1'b0, 2, 1, 1'b0, 6'd0, 32'h0000_0200, 4'b1000, 32'hAB00_0000, 32'h0,         1'b0);
    vecs[2] = mk("hld_err", 4'd7, 32'h0000_0102, SIZE_HALF, 1'b0, 32'h0,         32'hCAFE_1234, 1'b1, 0, 0, 1'b0, 6'd0, 32'h0000_0100, 4'b1100, 32'h0,         32'h0,         1'b1);
    vecs[3] = mk("hld102",  4'd9, 32'h0000_0102, SIZE_HALF, 1'b0, 32'h0,         32'hCAFE_1234, 1'b0, 1, 3, 1'b0, 6'd0, 32'h0000_0100, 4'b1100, 32'h0,         32'h0000_CAFE, 1'b0);
    vecs[4] = mk("bld101",  4'd4, 32'h0000_0101, SIZE_BYTE, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 0, 2, 1'b0, 6'd0, 32'h0000_0100, 4'b0010, 32'h0,         32'h0011_2233, 1'b0);
    vecs[5] = mk("dw_ld",   4'd5, 32'h0000_0300, SIZE_DOUBLE, 1'b0, 32'h0,       32'h0,         1'b0, 0, 0, 1'b1, 6'd5, 32'h0,         4'h0,    32'h0,         32'h0,         1'b0);
    vecs[6] = mk("dw_st",   4'd6, 32'h0000_0308, SIZE_DOUBLE, 1'b1, 32'h1,       32'h0,         1'b0, 0, 0, 1'b1, 6'd7, 32'h0,         4'h0,    32'h0,         32'h0,         1'b0);
`ifdef XIF_MEM_ALIGN_CHECK_EN
    vecs[7] = mk("hld101",  4'd8, 32'h0000_0101, SIZE_HALF, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 0, 0, 1'b1, 6'd4, 32'h0,         4'h0,    32'h0,         32'h0,         1'b0);
    vecs[8] = mk("wst102",  4'd10, 32'h0000_0102, SIZE_WORD, 1'b1, 32'hA1B2_C3D4, 32'h0,       1'b0, 0, 0, 1'b1, 6'd6, 32'h0,         4'h0,    32'h0,         32'h0,         1'b0);
`else
    vecs[7] = mk("hld101",  4'd8, 32'h0000_0101, SIZE_HALF, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 0, 0, 1'b0, 6'd0, 32'h0000_0100, 4'b0110, 32'h0,         32'h0011_2233, 1'b0);
    vecs[8] = mk("wst102",  4'd10, 32'h0000_0102, SIZE_WORD, 1'b1, 32'hA1B2_C3D4, 32'h0,       1'b0, 1, 0, 1'b0, 6'd0, 32'h0000_0100, 4'hF,   32'hC3D4_0000, 32'h0,         1'b0);
`endif
    vecs[9] = mk("wst20c",  4'd15, 32'h0000_020C, SIZE_WORD, 1'b1, 32'h55AA_55AA, 32'hFFFF_FFFF, 1'b0, 0, 1, 1'b0, 6'd0, 32'h0000_020C, 4'hF,  32'h55AA_55AA, 32'h0,         1'b0);

    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    check("rst.ready",        32'(x_mem_ready_o),        32'd1);
    check("rst.req",          32'(data_req_o),           32'd0);
    check("rst.addr",         data_addr_o,               32'd0);
    check("rst.be",           32'(data_be_o),            32'd0);
    check("rst.wdata",        data_wdata_o,              32'd0);
    check("rst.res_valid",    32'(x_mem_result_valid_o), 32'd0);
    check("rst.res_rdata",    x_mem_result_o.rdata,      32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Speculative load id=3: foreign commit id=5, then commit id=3 two cycles later.
    v = mk("spec_commit", 4'd3, 32'h0000_0104, SIZE_WORD, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 0,
           1'b0, 6'd0, 32'h0000_0104, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);
    quiet = 1;
    drive_req(v, 1'b1);
    next_cycle();
    x_mem_valid_i = 1'b0;
    x_mem_req_i   = '0;
    x_commit_valid_i = 1'b1;
    x_commit_i.id = 4'd5;
    x_commit_i.commit_kill = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (data_req_o !== 1'b0 || x_mem_ready_o !== 1'b0) quiet = 0;
      if (i == 2) begin
        x_commit_valid_i = 1'b1;
        x_commit_i.id = 4'd3;
      end
      next_cycle();
      x_commit_valid_i = 1'b0;
      x_commit_i = '0;
    end
    check("spec_commit.held", 32'(quiet), 32'd1);
    bus_txn(v);

    // Speculative load id=3 killed: back to IDLE, no bus access, no result.
    quiet = 1;
    drive_req(v, 1'b1);
    next_cycle();
    x_mem_valid_i = 1'b0;
    x_mem_req_i   = '0;
    x_commit_valid_i = 1'b1;
    x_commit_i.id = 4'd3;
    x_commit_i.commit_kill = 1'b1;
    check("spec_kill.wait_ready", 32'(x_mem_ready_o), 32'd0);
    next_cycle();
    x_commit_valid_i = 1'b0;
    x_commit_i = '0;
    check("spec_kill.ready", 32'(x_mem_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (data_req_o !== 1'b0 || x_mem_result_valid_o !== 1'b0) quiet = 0;
      next_cycle();
    end
    check("spec_kill.no_bus", 32'(quiet), 32'd1);

    // Commit in the same cycle as the speculative handshake.
    v = mk("spec_same", 4'd11, 32'h0000_0402, SIZE_HALF, 1'b1, 32'h0000_BEEF, 32'h0, 1'b0, 0, 0,
           1'b0, 6'd0, 32'h0000_0400, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0);
    drive_req(v, 1'b1);
    x_commit_valid_i = 1'b1;
    x_commit_i.id = 4'd11;
    x_commit_i.commit_kill = 1'b0;
    next_cycle();
    x_mem_valid_i = 1'b0;
    x_mem_req_i   = '0;
    x_commit_valid_i = 1'b0;
    x_commit_i = '0;
    bus_txn(v);

    // Reset pulsed in BUS_RESP, then a stray rvalid.
    v = vecs[0];
    drive_req(v, 1'b0);
    next_cycle();
    x_mem_valid_i = 1'b0;
    x_mem_req_i   = '0;
    data_gnt_i    = 1'b1;
    next_cycle();
    data_gnt_i    = 1'b0;
    check("rst_mid.in_resp_req", 32'(data_req_o), 32'd0);
    check("rst_mid.in_resp_rdy", 32'(x_mem_ready_o), 32'd0);
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5555_AAAA;
    next_cycle();
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    check("rst_mid.ready", 32'(x_mem_ready_o), 32'd1);
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      if (x_mem_result_valid_o !== 1'b0 || data_req_o !== 1'b0) quiet = 0;
      next_cycle();
    end
    check("rst_mid.no_result", 32'(quiet), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
